// File: rtl/fp_pkg.sv
// Shared FP32 constants, rounding-mode encodings and the integer-to-float FSM states.
`timescale 1ns/1ps
package fp_pkg;
  localparam logic [2:0] FRM_RNE = 3'b000;
  localparam logic [2:0] FRM_RTZ = 3'b001;
  localparam logic [2:0] FRM_RDN = 3'b010;
  localparam logic [2:0] FRM_RUP = 3'b011;
  localparam logic [2:0] FRM_RMM = 3'b100;

  localparam int         FP32_BIAS    = 127;
  // Exponent of a value whose leading one sits in bit 31 of the magnitude.
  localparam logic [7:0] I2F_EXP_BASE = 8'(FP32_BIAS + 31);

  typedef enum logic [1:0] {
    I2F_IDLE  = 2'd0,
    I2F_NORM  = 2'd1,
    I2F_ROUND = 2'd2,
    I2F_DONE  = 2'd3
  } i2f_state_e;
endpackage

// File: rtl/i2f_round.sv
// Combinational rounding stage: applies the rounding increment and packs the FP32 result.
`timescale 1ns/1ps
module i2f_round
  import fp_pkg::*;
(
  input  logic        i_sign,
  input  logic [7:0]  i_exp,
  input  logic [22:0] i_man,
  input  logic        i_g,
  input  logic        i_s,
  input  logic [2:0]  i_frm,
  output logic [31:0] o_d,
  output logic        o_nx
);
  logic        w_inc;
  logic [23:0] w_man_sum;
  logic [7:0]  w_exp;

  always_comb begin
    w_inc = 1'b0;
    case (i_frm)
      FRM_RNE: w_inc = i_g & (i_s | i_man[0]);
      FRM_RDN: w_inc = i_sign & (i_g | i_s);
      FRM_RUP: w_inc = ~i_sign & (i_g | i_s);
      FRM_RMM: w_inc = i_g;
      default: w_inc = 1'b0;  // RTZ and the reserved encodings truncate
    endcase
  end

  // A carry out of the mantissa leaves it all-zero and bumps the exponent.
  assign w_man_sum = {1'b0, i_man} + {23'd0, w_inc};
  assign w_exp     = i_exp + {7'd0, w_man_sum[23]};

  assign o_d  = {i_sign, w_exp, w_man_sum[22:0]};
  assign o_nx = i_g | i_s;
endmodule

// File: rtl/i2f_iter.sv
// Iterative 32-bit integer to FP32 converter (fcvt.s.w / fcvt.s.wu), one normalize step per cycle.
// Build option: define I2F_UNSIGNED_EN to honour is_unsigned; otherwise every operand is signed.
`timescale 1ns/1ps
module i2f_iter
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [2:0]  frm,
  input  logic        is_unsigned,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] d,
  output logic        NX
);
  i2f_state_e  r_state;
  i2f_state_e  w_state_next;
  logic [31:0] r_mag;
  logic [4:0]  r_lz;
  logic        r_sign;
  logic [2:0]  r_frm;
  logic [31:0] r_d;
  logic        r_nx;

  logic        w_uns;
  logic        w_sign;
  logic [31:0] w_mag;
  logic        w_accept;
  logic [7:0]  w_exp;
  logic [31:0] w_round_d;
  logic        w_round_nx;

`ifdef I2F_UNSIGNED_EN
  assign w_uns = is_unsigned;
`else
  // The port stays for interface stability but has no effect in this build.
  assign w_uns = is_unsigned & 1'b0;
`endif

  assign w_sign   = ~w_uns & a[31];
  assign w_mag    = w_sign ? (~a + 32'd1) : a;
  assign w_accept = in_valid & (r_state == I2F_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= I2F_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      I2F_IDLE:  if (in_valid) w_state_next = (a == 32'd0) ? I2F_DONE : I2F_NORM;
      I2F_NORM:  if (r_mag[31]) w_state_next = I2F_ROUND;
      I2F_ROUND: w_state_next = I2F_DONE;
      I2F_DONE:  if (out_ready) w_state_next = I2F_IDLE;
      default:   w_state_next = I2F_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == I2F_IDLE);
    out_valid = (r_state == I2F_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mag  <= 32'd0;
      r_lz   <= 5'd0;
      r_sign <= 1'b0;
      r_frm  <= FRM_RNE;
      r_d    <= 32'd0;
      r_nx   <= 1'b0;
    end else begin
      case (r_state)
        I2F_IDLE: begin
          if (w_accept) begin
            r_mag  <= w_mag;
            r_lz   <= 5'd0;
            r_sign <= w_sign;
            r_frm  <= frm;
            // A zero operand skips straight to DONE, so its result is loaded here.
            if (a == 32'd0) begin
              r_d  <= 32'd0;
              r_nx <= 1'b0;
            end
          end
        end
        I2F_NORM: begin
          if (!r_mag[31]) begin
            r_mag <= r_mag << 1;
            r_lz  <= r_lz + 5'd1;
          end
        end
        I2F_ROUND: begin
          r_d  <= w_round_d;
          r_nx <= w_round_nx;
        end
        default: ;
      endcase
    end
  end

  assign w_exp = I2F_EXP_BASE - {3'd0, r_lz};

  i2f_round u_round (
    .i_sign (r_sign),
    .i_exp  (w_exp),
    .i_man  (r_mag[30:8]),
    .i_g    (r_mag[7]),
    .i_s    (|r_mag[6:0]),
    .i_frm  (r_frm),
    .o_d    (w_round_d),
    .o_nx   (w_round_nx)
  );

  assign d  = r_d;
  assign NX = r_nx;
endmodule

// File: tb/tb_i2f_iter.sv
// Directed bench for i2f_iter: arithmetic reference model, per-cycle output compare, literal anchors.
`timescale 1ns/1ps
module tb_i2f_iter;
`ifdef I2F_UNSIGNED_EN
  localparam bit UNS_EN = 1'b1;
`else
  localparam bit UNS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'd0;
  logic [2:0]  frm = 3'd0;
  logic        is_unsigned = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] d;
  logic        NX;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_d = 32'd0;
  logic        exp_nx = 1'b0;
  bit          exp_armed = 1'b0;

  i2f_iter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .frm         (frm),
    .is_unsigned (is_unsigned),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .d           (d),
    .NX          (NX)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic longint unsigned magnitude(input logic [31:0] av, input logic un);
    logic sgn;
    sgn = av[31] && !(un && UNS_EN);
    return sgn ? (64'h1_0000_0000 - {32'd0, av}) : {32'd0, av};
  endfunction

  function automatic int msb_pos(input longint unsigned m);
    int p;
    p = -1;
    for (int i = 0; i < 33; i++) if (m[i]) p = i;
    return p;
  endfunction

  // Real-number view: value = sig * 2^(p-23) with sig in [2^23, 2^24), remainder rounded by frm.
  function automatic logic [32:0] model(input logic [31:0] av, input logic [2:0] fm, input logic un);
    logic sgn, up, nx;
    longint unsigned m, sig, rem, half;
    int p, sh;
    logic [7:0] e;
    sgn = av[31] && !(un && UNS_EN);
    m = magnitude(av, un);
    if (m == 0) return 33'd0;
    p = msb_pos(m);
    rem = 0;
    half = 0;
    if (p <= 23) begin
      sig = m << (23 - p);
    end else begin
      sh   = p - 23;
      sig  = m >> sh;
      rem  = m - (sig << sh);
      half = 64'd1 << (sh - 1);
    end
    nx = (rem != 0);
    case (fm)
      3'b000:  up = (rem > half) || (rem == half && rem != 0 && sig[0]);
      3'b010:  up = sgn && nx;
      3'b011:  up = !sgn && nx;
      3'b100:  up = (rem != 0) && (rem >= half);
      default: up = 1'b0;
    endcase
    sig = sig + {63'd0, up};
    if (sig == (64'd1 << 24)) begin
      sig = sig >> 1;
      p = p + 1;
    end
    e = 8'(127 + p);
    return {nx, sgn, e, sig[22:0]};
  endfunction

  function automatic int model_latency(input logic [31:0] av, input logic un);
    if (av == 32'd0) return 1;
    return 34 - msb_pos(magnitude(av, un));
  endfunction

  // Whenever a result is presented it must match the model for the operand in flight.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!exp_armed) chk("unexpected_out_valid", 32'd1, 32'd0);
      else begin
        chk("d", d, exp_d);
        chk("NX", {31'd0, NX}, {31'd0, exp_nx});
      end
    end
  end

  task automatic run_op(input logic [31:0] av, input logic [2:0] fm, input logic un,
                        input int hold, input bit lit, input logic [31:0] lit_d,
                        input logic lit_nx, input int lit_lat);
    logic [32:0] m;
    logic [31:0] d0;
    int lat;
    int w;
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    m = model(av, fm, un);
    exp_d = m[31:0];
    exp_nx = m[32];
    exp_armed = 1'b1;
    a = av; frm = fm; is_unsigned = un; in_valid = 1'b1;
    @(negedge clk);
    // Junk operand held valid while busy must be ignored.
    a = ~av; frm = 3'b111; is_unsigned = ~un;
    lat = 1;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    in_valid = 1'b0;
    chk("latency", 32'(lat), 32'(model_latency(av, un)));
    if (lit_lat > 0) chk("latency_lit", 32'(lat), 32'(lit_lat));
    if (!out_valid) return;
    if (lit) begin
      chk("d_lit", d, lit_d);
      chk("NX_lit", {31'd0, NX}, {31'd0, lit_nx});
    end
    d0 = d;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_d", d, d0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_armed = 1'b0;
    chk("post_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_in_ready", {31'd0, in_ready}, 32'd1);
    $display("op a=%h frm=%0d uns=%0d -> d=%h NX=%0d lat=%0d", av, fm, un, d0, m[32], lat);
  endtask

  initial begin
    logic [31:0] sweep [6];
    sweep[0] = 32'h12345678; sweep[1] = 32'hFFFFFFFD; sweep[2] = 32'h01000003;
    sweep[3] = 32'hFF000003; sweep[4] = 32'h80000001; sweep[5] = 32'h00FFFFFF;

    repeat (3) @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_d", d, 32'd0);
    chk("reset_NX", {31'd0, NX}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'h00000003, 3'b000, 1'b0, 0, 1, 32'h40400000, 1'b0, 33);
    run_op(32'hFFFFFFFF, 3'b000, 1'b0, 0, 1, 32'hBF800000, 1'b0, 0);
    run_op(32'h80000000, 3'b000, 1'b0, 0, 1, 32'hCF000000, 1'b0, 3);
    run_op(32'h80000000, 3'b000, 1'b1, 0, 1, UNS_EN ? 32'h4F000000 : 32'hCF000000, 1'b0, 3);
    run_op(32'h01000001, 3'b000, 1'b0, 0, 1, 32'h4B800000, 1'b1, 0);
    run_op(32'h01000001, 3'b011, 1'b0, 0, 1, 32'h4B800001, 1'b1, 0);
    run_op(32'hFEFFFFFF, 3'b010, 1'b0, 0, 1, 32'hCB800001, 1'b1, 0);
    run_op(32'h7FFFFFFF, 3'b000, 1'b0, 0, 1, 32'h4F000000, 1'b1, 0);
    run_op(32'h7FFFFFFF, 3'b001, 1'b0, 0, 1, 32'h4EFFFFFF, 1'b1, 0);
    run_op(32'h00000000, 3'b000, 1'b0, 5, 1, 32'h00000000, 1'b0, 1);

    // Reset in the middle of normalization must discard the operand.
    a = 32'h00000001; frm = 3'b000; is_unsigned = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      chk("rst_no_out_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
    $display("mid-conversion reset checked");
    run_op(32'h00000001, 3'b000, 1'b0, 0, 1, 32'h3F800000, 1'b0, 34);

    for (int v = 0; v < 6; v++)
      for (int f = 0; f < 8; f++)
        run_op(sweep[v], 3'(f), 1'(f % 2), 0, 0, 32'd0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
